// File: rtl/wts_pkg.sv
// Shared definitions for the wave-RAM arbiter: FSM encoding, port ids,
// address/data widths, default last address and the out-of-range read value.
package wts_pkg;

  localparam int WTS_AW = 10;
  localparam int WTS_DW = 8;

  localparam int WTS_ADDR_LAST_DEFAULT = 767;

  localparam logic [WTS_DW-1:0] WTS_OOR_RDATA = 8'hFF;

  // Port ids double as the round-robin last-grant flag.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_TG  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACK     = 2'd3
  } wts_state_e;

  function automatic logic addr_above(input logic [WTS_AW-1:0] a, input int unsigned last);
    return 32'(a) > last;
  endfunction

endpackage

// File: rtl/wts_rr_arb2.sv
// Two-way round-robin selector: a lone request wins outright; on a tie the
// port that was not granted last wins. Grant bit 0 = CPU, bit 1 = TG.
module wts_rr_arb2
  import wts_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (req_i == 2'b11) begin
      grant_o = (last_i == PORT_CPU) ? 2'b10 : 2'b01;
    end else begin
      grant_o = req_i;
    end
  end

endmodule

// File: rtl/wts_ram_arbiter.sv
// Arbitrates CPU and tone-generator access to a single-port wave RAM, one
// access per 4 cycles. Define WTS_ARB_ADDR_CHECK_EN to drop out-of-range writes
// and return 0xFF for out-of-range reads.
module wts_ram_arbiter
  import wts_pkg::*;
#(
  parameter int ADDR_LAST = WTS_ADDR_LAST_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [WTS_AW-1:0] cpu_a,
  input  logic [WTS_DW-1:0] cpu_d,
  output logic              cpu_ack,
  output logic [WTS_DW-1:0] cpu_q,
  input  logic              tg_req,
  input  logic [WTS_AW-1:0] tg_a,
  output logic              tg_ack,
  output logic [WTS_DW-1:0] tg_q,
  output logic              sram_we,
  output logic [WTS_AW-1:0] sram_a,
  output logic [WTS_DW-1:0] sram_d,
  input  logic [WTS_DW-1:0] sram_q,
  output wts_state_e        dbg_state_o
);

  // Handshake: req is a level held with its we/a/d until ack; ack is a single
  // cycle pulse three cycles after req is sampled in IDLE. The requester must
  // drop req in the cycle after ack, otherwise it is seen as a new request.

`ifdef WTS_ARB_ADDR_CHECK_EN
  localparam bit ADDR_CHECK_EN = 1'b1;
`else
  localparam bit ADDR_CHECK_EN = 1'b0;
`endif

  wts_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic              oor_q, oor_d;
  logic              sram_we_q, sram_we_d;
  logic [WTS_AW-1:0] sram_a_q, sram_a_d;
  logic [WTS_DW-1:0] sram_d_q, sram_d_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              tg_ack_q, tg_ack_d;
  logic [WTS_DW-1:0] cpu_q_q, cpu_q_d;
  logic [WTS_DW-1:0] tg_q_q, tg_q_d;

  logic [1:0]        grant;
  logic [WTS_AW-1:0] cand_a;
  logic [WTS_DW-1:0] rdata;

  wts_rr_arb2 u_rr (
    .req_i   ({tg_req, cpu_req}),
    .last_i  (last_q),
    .grant_o (grant)
  );

  assign cand_a = grant[1] ? tg_a : cpu_a;
  assign rdata  = oor_q ? WTS_OOR_RDATA : sram_q;

  // The sram_a/sram_d registers also serve as the latched winner address/data.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    we_d      = we_q;
    oor_d     = oor_q;
    sram_we_d = 1'b0;
    sram_a_d  = sram_a_q;
    sram_d_d  = sram_d_q;
    cpu_ack_d = 1'b0;
    tg_ack_d  = 1'b0;
    cpu_q_d   = cpu_q_q;
    tg_q_d    = tg_q_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          win_d     = grant[1] ? PORT_TG : PORT_CPU;
          last_d    = win_d;
          we_d      = grant[1] ? 1'b0 : cpu_we;
          oor_d     = ADDR_CHECK_EN && addr_above(cand_a, ADDR_LAST);
          sram_we_d = we_d && !oor_d;
          sram_a_d  = cand_a;
          sram_d_d  = grant[1] ? sram_d_q : cpu_d;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!we_q) begin
          if (win_q == PORT_TG) tg_q_d = rdata;
          else                  cpu_q_d = rdata;
        end
        cpu_ack_d = (win_q == PORT_CPU);
        tg_ack_d  = (win_q == PORT_TG);
        state_d   = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      last_q    <= PORT_CPU;
      win_q     <= PORT_CPU;
      we_q      <= 1'b0;
      oor_q     <= 1'b0;
      sram_we_q <= 1'b0;
      sram_a_q  <= '0;
      sram_d_q  <= '0;
      cpu_ack_q <= 1'b0;
      tg_ack_q  <= 1'b0;
      cpu_q_q   <= '0;
      tg_q_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      we_q      <= we_d;
      oor_q     <= oor_d;
      sram_we_q <= sram_we_d;
      sram_a_q  <= sram_a_d;
      sram_d_q  <= sram_d_d;
      cpu_ack_q <= cpu_ack_d;
      tg_ack_q  <= tg_ack_d;
      cpu_q_q   <= cpu_q_d;
      tg_q_q    <= tg_q_d;
    end
  end

  assign cpu_ack     = cpu_ack_q;
  assign cpu_q       = cpu_q_q;
  assign tg_ack      = tg_ack_q;
  assign tg_q        = tg_q_q;
  assign sram_we     = sram_we_q;
  assign sram_a      = sram_a_q;
  assign sram_d      = sram_d_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wts_ram_arbiter.sv
// Bench for wts_ram_arbiter: directed vector table, hand-written corner
// sequences and random two-port traffic checked by a transaction-level model.
module tb_wts_ram_arbiter;
  import wts_pkg::*;

`ifdef WTS_ARB_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int LAST = 767;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ram_clear = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [9:0] cpu_a = '0;
  logic [7:0] cpu_d = '0;
  logic       cpu_ack;
  logic [7:0] cpu_q;
  logic       tg_req = 1'b0;
  logic [9:0] tg_a = '0;
  logic       tg_ack;
  logic [7:0] tg_q;
  logic       sram_we;
  logic [9:0] sram_a;
  logic [7:0] sram_d;
  logic [7:0] sram_q = '0;
  wts_state_e dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int we300_cnt = 0;

  wts_ram_arbiter #(.ADDR_LAST(LAST)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .cpu_ack(cpu_ack), .cpu_q(cpu_q),
    .tg_req(tg_req), .tg_a(tg_a), .tg_ack(tg_ack), .tg_q(tg_q),
    .sram_we(sram_we), .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- wave RAM model ----------------
  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 1024; i++) mem[i] <= (i == 'h2FF) ? 8'hA5 : 8'h00;
    end else if (sram_we) begin
      mem[sram_a] <= sram_d;
    end else begin
      sram_q <= mem[sram_a];
    end
  end

  always @(negedge clk) if (sram_we && sram_a == 10'h300) we300_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit oob(input logic [9:0] a);
    return CHK && (int'(a) > LAST);
  endfunction

  // ---------------- reference model / scoreboard ----------------
  // Accesses are serialized: each granted access acks 3 cycles later, the
  // next grant is possible 4 cycles after the previous one, ties go to the
  // port not granted last. Read data is the memory image at grant time.
  logic [7:0] ref_mem [0:1023];
  logic [7:0] exp_q[$];
  bit         pend_valid, pend_port, pend_we, last_port;
  logic [9:0] pend_a;
  logic [7:0] pend_d;
  int         ack_cyc, free_cyc;
  logic [7:0] exp_cpu_q, exp_tg_q;

  always @(negedge clk) begin : model
    bit issue, ackc, p;
    if (ram_clear) begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = (i == 'h2FF) ? 8'hA5 : 8'h00;
    end
    if (reset) begin
      pend_valid = 1'b0; free_cyc = 0; last_port = 1'b0;
      exp_cpu_q = 8'h00; exp_tg_q = 8'h00; exp_q.delete();
    end else begin
      issue = pend_valid && (cyc == ack_cyc - 2);
      ackc  = pend_valid && (cyc == ack_cyc);
      check("cpu_ack", cpu_ack, ackc && !pend_port);
      check("tg_ack", tg_ack, ackc && pend_port);
      check("sram_we", sram_we, issue && pend_we && !oob(pend_a));
      if (issue) begin
        check("sram_a", sram_a, pend_a);
        if (pend_we) check("sram_d", sram_d, pend_d);
      end
      if (ackc) begin
        if (!pend_we) begin
          if (pend_port) exp_tg_q = exp_q.pop_front();
          else           exp_cpu_q = exp_q.pop_front();
        end
        pend_valid = 1'b0;
      end
      check("cpu_q", cpu_q, exp_cpu_q);
      check("tg_q", tg_q, exp_tg_q);
      if (!pend_valid && cyc >= free_cyc && (cpu_req || tg_req)) begin
        p = (cpu_req && tg_req) ? !last_port : tg_req;
        last_port = p; pend_valid = 1'b1; pend_port = p;
        ack_cyc = cyc + 3; free_cyc = cyc + 4;
        pend_we = p ? 1'b0 : cpu_we;
        pend_a  = p ? tg_a : cpu_a;
        pend_d  = cpu_d;
        if (pend_we) begin
          if (!oob(pend_a)) ref_mem[pend_a] = pend_d;
        end else begin
          exp_q.push_back(oob(pend_a) ? 8'hFF : ref_mem[pend_a]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic access(input bit port, input bit we, input logic [9:0] a,
                        input logic [7:0] d, output int lat);
    int start;
    bit got;
    @(posedge clk); #1;
    if (port) begin tg_req = 1'b1; tg_a = a; end
    else begin cpu_req = 1'b1; cpu_we = we; cpu_a = a; cpu_d = d; end
    start = cyc; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = port ? tg_ack : cpu_ack;
    end
    lat = got ? cyc - start : -1;
    @(posedge clk); #1;
    if (port) tg_req = 1'b0; else cpu_req = 1'b0;
  endtask

  bit ack_order[$];
  int max_lat_cpu, max_lat_tg;

  function automatic logic [9:0] rand_addr();
    return ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
  endfunction

  task automatic stream(input bit port, input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      int start;
      bit got;
      repeat ($urandom_range(0, gap_max) + 1) @(posedge clk);
      #1;
      if (port) begin tg_req = 1'b1; tg_a = rand_addr(); end
      else begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_a = rand_addr(); cpu_d = 8'($urandom_range(0, 255));
      end
      start = cyc; got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        got = port ? tg_ack : cpu_ack;
      end
      if (!got) check(port ? "tg_ack_timeout" : "cpu_ack_timeout", 0, 1);
      else begin
        ack_order.push_back(port);
        if (port && cyc - start > max_lat_tg) max_lat_tg = cyc - start;
        if (!port && cyc - start > max_lat_cpu) max_lat_cpu = cyc - start;
      end
      @(posedge clk); #1;
      if (port) tg_req = 1'b0; else cpu_req = 1'b0;
    end
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    bit         port;
    bit         we;
    logic [9:0] a;
    logic [7:0] d;
    logic [7:0] exp_cpu_q;
    logic [7:0] exp_tg_q;
  } vec_t;
  vec_t vecs [9];

  initial begin
    int lat, lat_tg, lat_cpu, c0, w0;
    vecs[0] = '{1'b0, 1'b1, 10'h010, 8'h5A, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 10'h010, 8'h00, 8'h5A, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 10'h2FF, 8'h00, 8'h5A, 8'hA5};
    vecs[3] = '{1'b0, 1'b1, 10'h000, 8'hC3, 8'h5A, 8'hA5};
    vecs[4] = '{1'b0, 1'b0, 10'h000, 8'h00, 8'hC3, 8'hA5};
    vecs[5] = '{1'b1, 1'b0, 10'h010, 8'h00, 8'hC3, 8'h5A};
    vecs[6] = '{1'b0, 1'b1, 10'h2FF, 8'h7E, 8'hC3, 8'h5A};
    vecs[7] = '{1'b1, 1'b0, 10'h2FF, 8'h00, 8'hC3, 8'h7E};
    vecs[8] = '{1'b0, 1'b0, 10'h2FF, 8'h00, 8'h7E, 8'h7E};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_tg_ack", tg_ack, 0);
    check("rst_sram_we", sram_we, 0);
    check("rst_sram_a", sram_a, 0);
    check("rst_sram_d", sram_d, 0);
    check("rst_cpu_q", cpu_q, 0);
    check("rst_tg_q", tg_q, 0);
    @(posedge clk); #1;
    reset = 1'b0; ram_clear = 1'b0;

    // Simultaneous first requests: TG wins the first tie.
    fork
      access(1'b1, 1'b0, 10'h100, 8'h00, lat_tg);
      access(1'b0, 1'b0, 10'h101, 8'h00, lat_cpu);
    join
    check("tie_tg_lat", lat_tg, 3);
    check("tie_cpu_lat", lat_cpu, 7);

    for (int i = 0; i < 9; i++) begin
      access(vecs[i].port, vecs[i].we, vecs[i].a, vecs[i].d, lat);
      check($sformatf("vec%0d_lat", i), lat, 3);
      check($sformatf("vec%0d_cpu_q", i), cpu_q, vecs[i].exp_cpu_q);
      check($sformatf("vec%0d_tg_q", i), tg_q, vecs[i].exp_tg_q);
    end

    // Reset during CAPTURE of a CPU write aborts the access.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 10'h020; cpu_d = 8'h99; c0 = cyc;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_capture", dbg_state, ST_CAPTURE);
    reset = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_cycle", cyc - c0, 3);
    check("abort_cpu_ack", cpu_ack, 0);
    check("abort_sram_we", sram_we, 0);
    check("abort_sram_a", sram_a, 0);
    check("abort_sram_d", sram_d, 0);
    check("abort_cpu_q", cpu_q, 0);
    check("abort_tg_q", tg_q, 0);
    check("abort_state", dbg_state, ST_IDLE);
    repeat (6) @(negedge clk);

    // Out-of-range address handling.
    w0 = we300_cnt;
    access(1'b0, 1'b1, 10'h300, 8'h33, lat);
    check("oor_wr_lat", lat, 3);
    check("oor_we_seen", we300_cnt - w0, CHK ? 0 : 1);
    access(1'b0, 1'b0, 10'h300, 8'h00, lat);
    check("oor_rd_lat", lat, 3);
    check("oor_rd_q", cpu_q, CHK ? 8'hFF : 8'h33);

    // Random traffic from both ports against the model.
    fork
      stream(1'b0, 12, 3);
      stream(1'b1, 12, 3);
    join
    check("rand_acks", ack_order.size(), 24);

    // Both ports back-to-back: grants must alternate.
    ack_order.delete(); max_lat_cpu = 0; max_lat_tg = 0;
    fork
      stream(1'b0, 4, 0);
      stream(1'b1, 4, 0);
    join
    check("alt_count", ack_order.size(), 8);
    for (int i = 1; i < ack_order.size(); i++)
      check($sformatf("alt_order%0d", i), ack_order[i] != ack_order[i-1], 1);
    check("alt_cpu_wait", max_lat_cpu <= 7, 1);
    check("alt_tg_wait", max_lat_tg <= 7, 1);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout, expected end of test");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wts_ram_arbiter.md
WTS_RAM_ARBITER -- requirements
Module: wts_ram_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the polarity and synchronicity are fixed.
REQ-002 Parameter: ADDR_LAST, default 767, highest valid wave-RAM word address.
REQ-003 Port: clk  in  1  sole clock; all logic on rising edge.
REQ-004 Port: reset  in  1  synchronous active-high reset.
REQ-005 Port: cpu_req / cpu_we / cpu_a / cpu_d  in  1/1/10/8  CPU access request, write flag, address, write data.
REQ-006 Port: cpu_ack / cpu_q  out  1/8  one-cycle completion pulse; last CPU read data.
REQ-007 Port: tg_req / tg_a  in  1/10  tone-generator read request and address (read-only).
REQ-008 Port: tg_ack / tg_q  out  1/8  one-cycle completion pulse; last tone-generator read data.
REQ-009 Port: sram_we / sram_a / sram_d  out  1/10/8  to wave RAM (RAM writes when we=1, else registers read data).
REQ-010 Port: sram_q  in  8  RAM read data, valid the cycle after address presented with we=0.

Function
REQ-011 FSM states SHALL be IDLE, ISSUE, CAPTURE, ACK; all outputs registered.
REQ-012 IDLE: if any req high, latch winner's we/a/d and port id, go ISSUE; else stay IDLE.
REQ-013 Arbitration SHALL be round-robin: on simultaneous requests grant the port not granted last; last-grant flag resets to CPU (TG wins first tie).
REQ-014 ISSUE: sram_a/sram_d = latched values, sram_we = latched we (always 0 for TG); go CAPTURE.
REQ-015 CAPTURE: on read, load sram_q into winner's q register at end of cycle; go ACK.
REQ-016 ACK: winner's ack = 1 for exactly this cycle; go IDLE.
REQ-017 Latency: req sampled in cycle 0 -> ack in cycle 3; one access per 4 cycles max.
REQ-018 sram_we SHALL be 1 only in ISSUE; sram_a/sram_d hold their last values elsewhere.
REQ-019 cpu_q/tg_q SHALL hold until that port's next read completes; CPU writes do not alter cpu_q.
REQ-020 Requester holds req/address/data stable until ack and drops req in the cycle after ack; a req dropped early SHALL still be completed and acked.
REQ-021 Requests arriving in CAPTURE/ACK/ISSUE SHALL wait; no request is lost while held.

Reset
REQ-022 reset SHALL force IDLE, cpu_ack=tg_ack=0, sram_we=0, sram_a=0, sram_d=0, cpu_q=tg_q=0x00, last-grant=CPU.
REQ-023 Reset mid-access SHALL abort it: no ack issued, no write after the reset cycle.

Configuration
REQ-024 With WTS_ARB_ADDR_CHECK_EN defined: address > ADDR_LAST SHALL suppress sram_we (write dropped) and return 0xFF as read data; ack timing unchanged.
REQ-025 Without WTS_ARB_ADDR_CHECK_EN: addresses pass through unchecked; out-of-range behaviour is the RAM's.

Structure
REQ-026 Shared package wts_pkg SHALL hold the FSM state encoding, port-id constants, ADDR_LAST default and the 0xFF out-of-range read value.
REQ-027 Round-robin selection SHALL be a sub-module wts_rr_arb2 (2 requests, last-grant in, one-hot grant out); no other sub-modules.

Verification
REQ-028 CPU write 0x5A @0x010 then CPU read @0x010 -> cpu_ack each at cycle 3, cpu_q=0x5A; tg_q unchanged.
REQ-029 cpu_req and tg_req high same cycle after reset -> TG served first (tg_ack cycle 3), CPU acked cycle 7.
REQ-030 Both requesting continuously for 8 accesses -> grants strictly alternate, no port waits more than one access.
REQ-031 Reset asserted in CAPTURE of a CPU write -> no cpu_ack, sram_we=0, all outputs at reset values next cycle.
REQ-032 With WTS_ARB_ADDR_CHECK_EN: CPU write 0x33 @0x300 -> sram_we stays 0; read @0x300 -> cpu_q=0xFF; without macro, sram_we=1 at 0x300.
REQ-033 TG read @ADDR_LAST (0x2FF) preloaded 0xA5 -> tg_q=0xA5 at tg_ack; sram_we never asserted for TG.
